prbs5_checker: RTL and testbench

- Serial receive-side checker for the team's 5-bit LFSR pattern generator.
- Generator polynomial is x^5+x^3+1: output recurrence b(k) = b(k-2) XOR b(k-5), period 31, reset seed 00001, first output bits 0,0,0,0,1,0,1,0,1,1.
- The checker self-synchronises to the incoming bit stream, declares lock, then counts bit errors using a flywheel predictor.
- It sits at the far end of a serial loopback link and feeds LED/7-segment status logic.

---
 rtl/prbs5_checker.sv | 111 +++++++++++
 tb/tb_prbs5_checker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising x^5+x^3+1 PRBS checker with flywheel error counting
module prbs5_checker #(
  parameter int LOCK_THRESHOLD = 8,
  parameter int WINDOW         = 16,
  parameter int LOSS_THRESHOLD = 4,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Data_In,
  input  logic             Valid,
  input  logic             Clear_Cnt,
  output logic             Locked,
  output logic             Bit_Err,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] Err_Count,
  output logic [CNT_W-1:0] Bit_Count
);
  localparam int WW = $clog2(WINDOW);
  localparam int BW = $clog2(WINDOW + 1);
  localparam logic [1:0] SEED   = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;
  localparam logic [7:0]    LT    = 8'(LOCK_THRESHOLD);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [BW-1:0] LOSS  = BW'(LOSS_THRESHOLD);
  logic [1:0]       r_state;
  logic [4:0]       r_hist;
  logic [2:0]       r_seed;
  logic [7:0]       r_match;
  logic [WW-1:0]    r_win;
  logic [BW-1:0]    r_bad;
  logic [CNT_W-1:0] r_err, r_bit;
  logic             r_bit_err;
  logic             w_pred, w_mis, w_lk, w_inc_err, w_inc_bit;
  logic [4:0]       w_hist_nxt;
  logic [2:0]       w_seed_nxt;
  logic [7:0]       w_match_nxt;
  logic [BW-1:0]    w_bad_nxt;
  logic [CNT_W-1:0] w_err_base, w_bit_base;
  always_comb begin
    w_pred      = r_hist[1] ^ r_hist[4];
    w_mis       = Valid && (Data_In != w_pred);
    w_lk        = r_state == LOCKED;
    // once locked the history free-runs on its own prediction, so one bad bit costs one error
    w_hist_nxt  = {r_hist[3:0], w_lk ? w_pred : Data_In};
    w_seed_nxt  = (r_seed == 3'd5) ? 3'd5 : r_seed + 3'd1;
    w_match_nxt = r_match + 8'd1;
    w_bad_nxt   = r_bad + BW'(1);
    w_inc_err   = w_mis && w_lk;
    w_inc_bit   = Valid && w_lk;
    w_err_base  = Clear_Cnt ? '0 : r_err;
    w_bit_base  = Clear_Cnt ? '0 : r_bit;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= SEED;
      r_hist    <= '0;
      r_seed    <= '0;
      r_match   <= '0;
      r_win     <= '0;
      r_bad     <= '0;
      r_err     <= '0;
      r_bit     <= '0;
      r_bit_err <= 1'b0;
    end else begin
      r_err     <= (w_inc_err && !(&w_err_base)) ? w_err_base + CNT_W'(1) : w_err_base;
      r_bit     <= (w_inc_bit && !(&w_bit_base)) ? w_bit_base + CNT_W'(1) : w_bit_base;
      r_bit_err <= w_inc_err;
      if (Valid) begin
        r_hist <= w_hist_nxt;
        if (r_state == SEED) begin
          r_seed <= w_seed_nxt;
          if (w_seed_nxt == 3'd5 && |w_hist_nxt) r_state <= VERIFY;
        end else if (r_state == VERIFY) begin
          if (w_mis) begin
            r_state <= SEED;
            r_seed  <= '0;
            r_match <= '0;
          end else if (w_match_nxt == LT) begin
            r_state <= LOCKED;
            r_match <= '0;
            r_win   <= '0;
            r_bad   <= '0;
          end else begin
            r_match <= w_match_nxt;
          end
        end else if (r_state == LOCKED) begin
          if (w_mis && w_bad_nxt >= LOSS) begin
            r_state <= SEED;
            r_seed  <= '0;
            r_match <= '0;
          end else if (r_win == WLAST) begin
            r_win <= '0;
            r_bad <= '0;
          end else begin
            r_win <= r_win + WW'(1);
            r_bad <= w_mis ? w_bad_nxt : r_bad;
          end
        end else begin
          r_state <= SEED;
        end
      end
    end
  end
  assign Locked    = w_lk;
  assign Bit_Err   = r_bit_err;
  assign State     = r_state;
  assign Err_Count = r_err;
  assign Bit_Count = r_bit;
endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: directed checks of sync, lock, error counting, loss of lock and reset
module tb_prbs5_checker;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Data_In = 1'b0;
  logic        Valid = 1'b0;
  logic        Clear_Cnt = 1'b0;
  logic        Locked, Bit_Err;
  logic [1:0]  State;
  logic [15:0] Err_Count, Bit_Count;
  int n_chk = 0;
  int n_fail = 0;
  int p = 0;
  int nv;
  bit seq [0:30];
  prbs5_checker dut (
    .CLK(CLK), .RESET(RESET), .Data_In(Data_In), .Valid(Valid), .Clear_Cnt(Clear_Cnt),
    .Locked(Locked), .Bit_Err(Bit_Err), .State(State), .Err_Count(Err_Count), .Bit_Count(Bit_Count)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send_gen(input bit flip);
    Data_In = seq[p % 31] ^ flip;
    Valid = 1'b1;
    p++;
    tick();
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    Valid = 1'b0;
    tick();
    RESET = 1'b0;
    p = 0;
  endtask
  initial begin
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0; seq[4] = 1;
    for (int k = 5; k < 31; k++) seq[k] = seq[k-2] ^ seq[k-5];
    // scenario 1: acquisition from reset
    tick();
    chk("reset_outputs", {Locked, Bit_Err, State, Err_Count, Bit_Count}, 64'd0);
    RESET = 1'b0;
    for (int i = 1; i <= 4; i++) send_gen(0);
    chk("seed_after_4", State, 2'b00);
    send_gen(0);
    chk("verify_after_5", State, 2'b01);
    for (int i = 6; i <= 12; i++) send_gen(0);
    chk("verify_after_12", {Locked, State}, {1'b0, 2'b01});
    send_gen(0);
    chk("locked_after_13", {Locked, State}, {1'b1, 2'b10});
    for (int i = 14; i <= 200; i++) send_gen(0);
    chk("s1_err", Err_Count, 16'd0);
    chk("s1_bits", Bit_Count, 16'd187);
    // scenario 2: single inverted bit
    send_gen(1);
    chk("s2_pulse", {Bit_Err, Locked, Err_Count}, {1'b1, 1'b1, 16'd1});
    send_gen(0);
    chk("s2_pulse_end", Bit_Err, 1'b0);
    for (int i = 0; i < 20; i++) send_gen(0);
    chk("s2_err_hold", {Locked, Err_Count}, {1'b1, 16'd1});
    chk("s2_bits", Bit_Count, 16'd209);
    // scenario 3: burst of 4 errors forces loss, then relock
    Valid = 1'b0;
    Clear_Cnt = 1'b1;
    tick();
    Clear_Cnt = 1'b0;
    chk("s3_clear", {Err_Count, Bit_Count, State}, {16'd0, 16'd0, 2'b10});
    for (int i = 0; i < 3; i++) send_gen(1);
    chk("s3_three_bad", {Locked, Err_Count}, {1'b1, 16'd3});
    send_gen(1);
    chk("s3_lost", {Locked, State, Err_Count, Bit_Count}, {1'b0, 2'b00, 16'd4, 16'd4});
    for (int i = 1; i <= 12; i++) send_gen(0);
    chk("s3_relock_12", State, 2'b01);
    send_gen(0);
    chk("s3_relock_13", {Locked, State, Err_Count}, {1'b1, 2'b10, 16'd4});
    // scenario 4: stuck-at-0 never locks; spread errors and window boundaries
    do_reset();
    Data_In = 1'b0;
    Valid = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("s4_stuck0", {Locked, State}, {1'b0, 2'b00});
    for (int i = 0; i < 13; i++) send_gen(0);
    chk("s4_locked", State, 2'b10);
    for (int i = 0; i <= 50; i++) begin
      send_gen(i == 3 || i == 19 || i == 35 || (i >= 47 && i <= 50));
      if (i == 35) chk("s4_spread3", {Locked, Err_Count}, {1'b1, 16'd3});
    end
    chk("s4_window_clear", {Locked, Err_Count}, {1'b1, 16'd7});
    for (int i = 51; i <= 63; i++) send_gen(i == 63);
    chk("s4_last_bit_loss", {State, Err_Count, Bit_Count}, {2'b00, 16'd8, 16'd64});
    // scenario 5: Valid toggling counts only valid bits
    do_reset();
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) begin
        send_gen(0);
        nv++;
      end else begin
        Valid = 1'b0;
        Data_In = ~Data_In;
        tick();
      end
      chk($sformatf("s5_state_c%0d", c), {Bit_Err, State},
          {1'b0, (nv < 5) ? 2'b00 : (nv < 13) ? 2'b01 : 2'b10});
    end
    chk("s5_bits", {Err_Count, Bit_Count}, {16'd0, 16'd7});
    // scenario 6: clear with a mismatching bit, then reset while locked
    Clear_Cnt = 1'b1;
    send_gen(1);
    Clear_Cnt = 1'b0;
    chk("s6_clear_mis", {Bit_Err, Err_Count, Bit_Count}, {1'b1, 16'd1, 16'd1});
    RESET = 1'b1;
    Valid = 1'b1;
    Data_In = 1'b1;
    tick();
    RESET = 1'b0;
    chk("s6_reset", {Locked, Bit_Err, State, Err_Count, Bit_Count}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
